vga_timing_gen: RTL

Pixel-timing front end of the VGA controller for 640x480 at 60 Hz. It divides the system clock down to a pixel-rate enable and runs the horizontal and vertical counters. It drives the pixel coordinates consumed by the video generator, then registers that generator's combinational RGB together with delayed sync and blank. The result is one pixel-aligned bundle for the external video DAC (ADV7123-style: clock, blank_n, sync_n, 8-bit RGB).

---
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel coordinates out to the video generator, its RGB
// back in, and the registered DAC-side signals (rgb, syncs, blank, clock).
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       vga_clk;
  logic       frame_start;

  modport master (
    output x, y,
    input  r_in, g_in, b_in,
    output vga_r, vga_g, vga_b,
    output vga_hs, vga_vs, vga_blank_n,
    output vga_sync_n, vga_clk, frame_start
  );

  modport slave (
    input  x, y,
    output r_in, g_in, b_in,
    input  vga_r, vga_g, vga_b,
    input  vga_hs, vga_vs, vga_blank_n,
    input  vga_sync_n, vga_clk, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-timing front end: clock divider, h/v counters, registered DAC bundle.
// Ports: clk, rst (async, active-high), vga (master side of vga_timing_gen_if).
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic          pix_en;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;

  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  // Generator RGB is a multicycle path from x/y; it is only sampled here,
  // one pixel after x/y moved, which keeps rgb/sync/blank aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (pix_en) begin
      r_q     <= active ? vga.r_in : 8'd0;
      g_q     <= active ? vga.g_in : 8'd0;
      b_q     <= active ? vga.b_in : 8'd0;
      hs_q    <= hs_raw;
      vs_q    <= vs_raw;
      blank_q <= active;
    end
  end

  assign vga.x           = h_cnt;
  assign vga.y           = v_cnt;
  assign vga.vga_r       = r_q;
  assign vga.vga_g       = g_q;
  assign vga.vga_b       = b_q;
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_blank_n = blank_q;
  assign vga.vga_sync_n  = 1'b0;
  // High for the second half of the pixel so the DAC samples settled data.
  assign vga.vga_clk     = (div_cnt >= DIV_HALF);
  assign vga.frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
endmodule
